// File: rtl/symbol_packer_if.sv
// Output word stream of the symbol packer: valid/ready handshake with
// the packed word and the number of valid symbols in it.
interface symbol_packer_if #(
  parameter int SYM_W         = 3,
  parameter int SYMS_PER_WORD = 4,
  parameter int CNT_W         = $clog2(SYMS_PER_WORD + 1)
);
  logic                           m_valid;
  logic                           m_ready;
  logic [SYM_W*SYMS_PER_WORD-1:0] m_data;
  logic [CNT_W-1:0]               m_count;

  modport master (output m_valid, output m_data, output m_count, input m_ready);
  modport slave  (input m_valid, input m_data, input m_count, output m_ready);
endinterface

// File: rtl/symbol_packer.sv
// Pops symbols from the upstream circular buffer and packs them LSB-first
// into words; flush drains a trailing partial word, zero-padded.
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | collecting symbols; pops allowed while room remains in the word
// HOLD  | word presented on m_valid, held stable until m_ready
module symbol_packer #(
  parameter int SYM_W         = 3,
  parameter int SYMS_PER_WORD = 4,
  parameter int CNT_W         = $clog2(SYMS_PER_WORD + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [SYM_W-1:0] fifo_dout,
  output logic             fifo_rd,
  input  logic             flush,
  symbol_packer_if.master  m_if,
  output logic             busy
);
  localparam int W = SYM_W * SYMS_PER_WORD;
  localparam logic [CNT_W:0]   FULL     = (CNT_W + 1)'(SYMS_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SYMS_PER_WORD - 1);
  localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(SYMS_PER_WORD);

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] collected, collected_nxt;
  logic             inflight, inflight_nxt;
  logic             flush_pend, flush_pend_nxt;
  logic [W-1:0]     shreg, shreg_nxt;
  logic [CNT_W-1:0] count, count_nxt;

  logic             handshake_now;
  logic [CNT_W:0]   room_cnt;

  // State and datapath registers; reset drops any partial word and in-flight pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= FILL;
      collected  <= '0;
      inflight   <= 1'b0;
      flush_pend <= 1'b0;
      shreg      <= '0;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      collected  <= collected_nxt;
      inflight   <= inflight_nxt;
      flush_pend <= flush_pend_nxt;
      shreg      <= shreg_nxt;
      count      <= count_nxt;
    end
  end

  // Pop request, symbol capture, flush handling and next-state decode.
  always_comb begin
    state_nxt      = state;
    collected_nxt  = collected;
    flush_pend_nxt = flush_pend;
    shreg_nxt      = shreg;
    count_nxt      = count;

    handshake_now = (state == HOLD) & m_if.m_ready;
    // During the handshake the word is already gone, so the room check
    // starts from an empty word; this keeps the pop stream bubble-free.
    room_cnt = (handshake_now ? '0 : {1'b0, collected}) + {{CNT_W{1'b0}}, inflight};
    fifo_rd  = ~fifo_empty & ~flush_pend & (room_cnt < FULL) &
               ((state == FILL) | handshake_now);
    inflight_nxt = fifo_rd;

    case (state)
      FILL: begin
        if (inflight) begin
          for (int k = 0; k < SYMS_PER_WORD; k++) begin
            if (collected == CNT_W'(k)) shreg_nxt[k*SYM_W +: SYM_W] = fifo_dout;
          end
          collected_nxt = collected + CNT_W'(1);
        end
        if (inflight && (collected == LAST_IDX)) begin
          // Word completes; a flush landing here is absorbed by this word.
          state_nxt      = HOLD;
          count_nxt      = WORD_CNT;
          flush_pend_nxt = 1'b0;
        end else if (flush_pend && !inflight) begin
          state_nxt      = HOLD;
          count_nxt      = collected;
          flush_pend_nxt = 1'b0;
        end else if (flush && ((collected != '0) || inflight)) begin
          flush_pend_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (m_if.m_ready) begin
          state_nxt     = FILL;
          collected_nxt = '0;
          shreg_nxt     = '0;
          count_nxt     = '0;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  assign m_if.m_valid = (state == HOLD);
  assign m_if.m_data  = shreg;
  assign m_if.m_count = count;
  assign busy         = (collected != '0) | inflight | (state == HOLD) | flush_pend;
endmodule

// File: tb/tb_symbol_packer.sv
// Directed bench for symbol_packer: a small circular-buffer model feeds it,
// expected words go into a scoreboard queue and are checked on handshake.
module tb_symbol_packer;
  localparam int SYM_W = 3;
  localparam int SPW   = 4;
  localparam int CNT_W = $clog2(SPW + 1);
  localparam int W     = SYM_W * SPW;

  typedef struct packed {
    logic [W-1:0]     d;
    logic [CNT_W-1:0] c;
  } word_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             fifo_empty;
  logic [SYM_W-1:0] fifo_dout = '0;
  logic             fifo_rd;
  logic             flush = 1'b0;
  logic             busy;

  symbol_packer_if #(.SYM_W(SYM_W), .SYMS_PER_WORD(SPW), .CNT_W(CNT_W)) m_if ();

  symbol_packer #(.SYM_W(SYM_W), .SYMS_PER_WORD(SPW), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd    (fifo_rd),
    .flush      (flush),
    .m_if       (m_if),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Upstream buffer model: 8 entries, registered read data.
  logic [SYM_W-1:0] mem [8];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp == rp);
  always @(posedge clock) begin
    if (fifo_rd) begin
      fifo_dout <= mem[rp & 7];
      rp <= rp + 1;
    end
  end

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    words = 0;
  int    valid_cyc = 0;
  int    rd_cnt = 0;
  int    rd_first = -1;
  int    rd_last = -1;
  word_t exp_q[$];
  word_t e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: pop legality, pop statistics, and scoreboard compare on handshake.
  always @(negedge clock) begin
    if (fifo_rd) begin
      check("rd_while_empty", 32'(fifo_empty), 32'd0);
      rd_cnt++;
      if (rd_first < 0) rd_first = cyc;
      rd_last = cyc;
    end
    if (m_if.m_valid) begin
      valid_cyc++;
      if (m_if.m_ready) begin
        words++;
        check("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("m_data", 32'(m_if.m_data), 32'(e.d));
          check("m_count", 32'(m_if.m_count), 32'(e.c));
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_sym(input logic [SYM_W-1:0] v);
    int n = 0;
    while ((wp - rp) >= 8 && n < 200) begin
      step();
      n++;
    end
    check("push_timeout", 32'(n < 200), 32'd1);
    mem[wp & 7] = v;
    wp = wp + 1;
  endtask

  task automatic push_step(input logic [SYM_W-1:0] v);
    push_sym(v);
    step();
  endtask

  task automatic expect_word(input logic [W-1:0] d, input logic [CNT_W-1:0] c);
    word_t w;
    w.d = d;
    w.c = c;
    exp_q.push_back(w);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic clear_stats();
    words = 0;
    valid_cyc = 0;
    rd_cnt = 0;
    rd_first = -1;
    rd_last = -1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Directed sequence.
  initial begin
    logic [SYM_W-1:0] syms [10];
    m_if.m_ready = 1'b0;
    #2 reset = 1'b1;
    step(); step(); step();
    check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    check("rst_m_valid", 32'(m_if.m_valid), 32'd0);
    check("rst_m_data", 32'(m_if.m_data), 32'd0);
    check("rst_m_count", 32'(m_if.m_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();

    // Single full word.
    clear_stats();
    m_if.m_ready = 1'b1;
    expect_word(12'o4321, 3'd4);
    push_step(3'd1); push_step(3'd2); push_step(3'd3); push_step(3'd4);
    wait_idle(50);
    check("t1_words", 32'(words), 32'd1);
    check("t1_valid_cycles", 32'(valid_cyc), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);

    // Sustained stream of 16 symbols.
    clear_stats();
    for (int i = 0; i < 4; i++) expect_word((i % 2 == 0) ? 12'o3210 : 12'o7654, 3'd4);
    for (int i = 0; i < 16; i++) push_step(3'(i % 8));
    wait_idle(100);
    check("t2_words", 32'(words), 32'd4);
    check("t2_pops", 32'(rd_cnt), 32'd16);
    check("t2_pop_span", 32'((rd_last - rd_first + 1) <= 19), 32'd1);

    // Back-pressure with 10 symbols queued.
    clear_stats();
    m_if.m_ready = 1'b0;
    syms = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    expect_word(12'o4321, 3'd4);
    expect_word(12'o0765, 3'd4);
    expect_word(12'o0021, 3'd2);
    for (int i = 0; i < 10; i++) push_step(syms[i]);
    check("t3_hold_data_early", 32'(m_if.m_data), 32'o4321);
    for (int i = 0; i < 10; i++) step();
    check("t3_hold_valid", 32'(m_if.m_valid), 32'd1);
    check("t3_hold_data_late", 32'(m_if.m_data), 32'o4321);
    check("t3_hold_count", 32'(m_if.m_count), 32'd4);
    check("t3_hold_pops", 32'(rd_cnt), 32'd4);
    m_if.m_ready = 1'b1;
    begin
      int n = 0;
      while (words < 2 && n < 30) begin
        step();
        n++;
      end
    end
    step(); step(); step(); step();
    check("t3_words_after_release", 32'(words), 32'd2);
    check("t3_residual_valid", 32'(m_if.m_valid), 32'd0);
    check("t3_residual_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_idle(50);
    check("t3_words_total", 32'(words), 32'd3);
    check("t3_pops_total", 32'(rd_cnt), 32'd10);

    // Partial word via flush issued while the last pop is in flight.
    clear_stats();
    expect_word(12'o0065, 3'd2);
    push_step(3'd5);
    push_step(3'd6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_idle(50);
    check("t4_words", 32'(words), 32'd1);

    // Flush while idle produces nothing.
    clear_stats();
    check("t4_idle_busy", 32'(busy), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("t4_idle_valid_cycles", 32'(valid_cyc), 32'd0);
    check("t4_idle_busy_after", 32'(busy), 32'd0);

    // Reset with three symbols collected and one in flight.
    clear_stats();
    push_step(3'd1); push_step(3'd2); push_step(3'd3); push_step(3'd4);
    check("t5_busy_before_reset", 32'(busy), 32'd1);
    check("t5_data_before_reset", 32'(m_if.m_data), 32'o0321);
    reset = 1'b1;
    #1;
    check("t5_rst_fifo_rd", 32'(fifo_rd), 32'd0);
    check("t5_rst_m_valid", 32'(m_if.m_valid), 32'd0);
    check("t5_rst_m_data", 32'(m_if.m_data), 32'd0);
    check("t5_rst_m_count", 32'(m_if.m_count), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    step(); step();
    reset = 1'b0;
    step();
    expect_word(12'o7777, 3'd4);
    push_step(3'd7); push_step(3'd7); push_step(3'd7); push_step(3'd7);
    wait_idle(50);
    check("t5_words", 32'(words), 32'd1);

    // Flush coinciding with the capture that completes a word.
    clear_stats();
    expect_word(12'o1111, 3'd4);
    push_step(3'd1); push_step(3'd1); push_step(3'd1); push_step(3'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_idle(50);
    for (int i = 0; i < 6; i++) step();
    check("t6_words", 32'(words), 32'd1);
    check("t6_valid_cycles", 32'(valid_cyc), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
